// File: rtl/dual_port_ram_pkg.sv
// Shared types for the dual_port_ram port-0 arbiter.
// RAM_ARB_BURST_EN enables burst-hold arbitration in the arbiter.
package dual_port_ram_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B
    } owner_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter with owner FSM and priority pointer.
// RAM_ARB_BURST_EN: owner keeps the grant for up to MAX_BURST cycles.
module rr_arbiter_2
    import dual_port_ram_pkg::*;
`ifdef RAM_ARB_BURST_EN
#(
    parameter int MAX_BURST = 4
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    owner_t  owner;
    owner_t  owner_nxt;
    req_id_t last;
    req_id_t last_q;
    logic    tie_a;

    // The owner of the previous cycle is the freshest pointer value.
    always_comb begin
        unique case (owner)
            OWN_A:   last = REQ_A;
            OWN_B:   last = REQ_B;
            default: last = last_q;
        endcase
    end

`ifdef RAM_ARB_BURST_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] burst_nxt;
    logic          hold;

    assign hold = burst_cnt < CW'(MAX_BURST);

    always_comb begin
        tie_a = (last == REQ_B);
        if (owner == OWN_A && hold)
            tie_a = 1'b1;
        else if (owner == OWN_B && hold)
            tie_a = 1'b0;
    end

    always_comb begin
        burst_nxt = '0;
        if ((gnt_a && owner == OWN_A) || (gnt_b && owner == OWN_B))
            burst_nxt = hold ? burst_cnt + 1'b1 : burst_cnt;
        else if (gnt_a || gnt_b)
            burst_nxt = CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            burst_cnt <= '0;
        else
            burst_cnt <= burst_nxt;
    end
`else
    assign tie_a = (last == REQ_B);
`endif

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            gnt_a = req_a && (!req_b || tie_a);
            gnt_b = req_b && (!req_a || !tie_a);
        end
    end

    always_comb begin
        owner_nxt = IDLE;
        unique case (1'b1)
            gnt_a:   owner_nxt = OWN_A;
            gnt_b:   owner_nxt = OWN_B;
            default: owner_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner  <= IDLE;
            last_q <= REQ_B;
        end else begin
            owner  <= owner_nxt;
            last_q <= last;
        end
    end

endmodule

// File: rtl/dual_port_ram_arbiter.sv
// Shares dual_port_ram port 0 between requesters A and B.
// RAM_ARB_BURST_EN selects burst-hold arbitration (MAX_BURST grants).
module dual_port_ram_arbiter
    import dual_port_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = 4
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic                  rvalid_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  ram_port_en_0,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr_0,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out_0
);

    if (MAX_BURST < 1) begin : g_bad_burst
        $error("MAX_BURST must be at least 1");
    end

    logic rd_pend_a;
    logic rd_pend_b;

`ifdef RAM_ARB_BURST_EN
    rr_arbiter_2 #(.MAX_BURST(MAX_BURST)) u_arb (
`else
    rr_arbiter_2 u_arb (
`endif
        .clk   (clk),
        .rst   (rst),
        .req_a (req_a),
        .req_b (req_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    always_comb begin
        ram_port_en_0 = gnt_a | gnt_b;
        ram_wr_en     = 1'b0;
        ram_addr_0    = '0;
        ram_data_in   = '0;
        unique case (1'b1)
            gnt_a: begin
                ram_wr_en   = we_a;
                ram_addr_0  = addr_a;
                ram_data_in = wdata_a;
            end
            gnt_b: begin
                ram_wr_en   = we_b;
                ram_addr_0  = addr_b;
                ram_data_in = wdata_b;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_a <= 1'b0;
            rd_pend_b <= 1'b0;
        end else begin
            rd_pend_a <= gnt_a & ~we_a;
            rd_pend_b <= gnt_b & ~we_b;
        end
    end

    // A response landing in a reset cycle is dropped.
    assign rvalid_a = rd_pend_a & ~rst;
    assign rvalid_b = rd_pend_b & ~rst;
    assign rdata_a  = rvalid_a ? ram_data_out_0 : '0;
    assign rdata_b  = rvalid_b ? ram_data_out_0 : '0;

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Self-checking bench for dual_port_ram_arbiter with a behavioural RAM.
// Burst-mode sequences run when RAM_ARB_BURST_EN is defined.
module tb_dual_port_ram_arbiter;

    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_a = 1'b0, we_a = 1'b0;
    logic [AW-1:0] addr_a = '0;
    logic [DW-1:0] wdata_a = '0;
    logic          req_b = 1'b0, we_b = 1'b0;
    logic [AW-1:0] addr_b = '0;
    logic [DW-1:0] wdata_b = '0;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          ram_port_en_0, ram_wr_en;
    logic [AW-1:0] ram_addr_0;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out_0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dual_port_ram_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MAXB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_a          (req_a),
        .we_a           (we_a),
        .addr_a         (addr_a),
        .wdata_a        (wdata_a),
        .req_b          (req_b),
        .we_b           (we_b),
        .addr_b         (addr_b),
        .wdata_b        (wdata_b),
        .gnt_a          (gnt_a),
        .gnt_b          (gnt_b),
        .rvalid_a       (rvalid_a),
        .rdata_a        (rdata_a),
        .rvalid_b       (rvalid_b),
        .rdata_b        (rdata_b),
        .ram_port_en_0  (ram_port_en_0),
        .ram_wr_en      (ram_wr_en),
        .ram_addr_0     (ram_addr_0),
        .ram_data_in    (ram_data_in),
        .ram_data_out_0 (ram_data_out_0)
    );

    // Registered-read RAM, port 0 only.
    logic [DW-1:0] ram_mem [16];
    logic [DW-1:0] ram_q = '0;
    initial for (int i = 0; i < 16; i++) ram_mem[i] = '0;
    always @(posedge clk) begin
        if (ram_port_en_0) begin
            if (ram_wr_en) ram_mem[ram_addr_0] <= ram_data_in;
            else           ram_q <= ram_mem[ram_addr_0];
        end
    end
    assign ram_data_out_0 = ram_q;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_str(input string name, input string act,
                             input string exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %s want %s", name, act, exp);
        end
    endtask

    // Reference model and read-data scoreboard, evaluated mid-cycle.
    bit            m_last = 1'b1;
    int            m_owner = 0;
    int            m_cnt = 0;
    bit            m_pa = 1'b0, m_pb = 1'b0;
    logic [DW-1:0] m_mem [16];
    logic [DW-1:0] q_a [$];
    logic [DW-1:0] q_b [$];
    initial for (int i = 0; i < 16; i++) m_mem[i] = '0;

    always @(negedge clk) begin : mon
        bit            ga, gb, va, vb, ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, da, db;
        ga = 1'b0;
        gb = 1'b0;
        if (!rst) begin
            if (req_a && req_b) begin
`ifdef RAM_ARB_BURST_EN
                if (m_owner == 1 && m_cnt < MAXB)      ga = 1'b1;
                else if (m_owner == 2 && m_cnt < MAXB) gb = 1'b1;
                else if (m_last)                       ga = 1'b1;
                else                                   gb = 1'b1;
`else
                if (m_last) ga = 1'b1;
                else        gb = 1'b1;
`endif
            end else begin
                ga = req_a;
                gb = req_b;
            end
        end
        ewe = ga ? we_a : (gb ? we_b : 1'b0);
        ea  = ga ? addr_a : (gb ? addr_b : '0);
        ed  = ga ? wdata_a : (gb ? wdata_b : '0);
        check("gnt", 32'({gnt_a, gnt_b}), 32'({ga, gb}));
        check("ram_bus",
              32'({ram_port_en_0, ram_wr_en, ram_addr_0, ram_data_in}),
              32'({ga | gb, ewe, ea, ed}));
        va = m_pa && !rst;
        vb = m_pb && !rst;
        da = '0;
        db = '0;
        if (va && q_a.size() > 0) da = q_a.pop_front();
        if (vb && q_b.size() > 0) db = q_b.pop_front();
        check("resp_a", 32'({rvalid_a, rdata_a}), 32'({va, da}));
        check("resp_b", 32'({rvalid_b, rdata_b}), 32'({vb, db}));
        if (rst) begin
            m_last = 1'b1; m_owner = 0; m_cnt = 0;
            m_pa = 1'b0; m_pb = 1'b0;
            q_a.delete(); q_b.delete();
        end else begin
            m_pa = ga && !we_a;
            m_pb = gb && !we_b;
            if (m_pa) q_a.push_back(m_mem[addr_a]);
            if (m_pb) q_b.push_back(m_mem[addr_b]);
            if (ga && we_a) m_mem[addr_a] = wdata_a;
            if (gb && we_b) m_mem[addr_b] = wdata_b;
            if (ga) begin
                m_cnt = (m_owner == 1) ? ((m_cnt < MAXB) ? m_cnt + 1 : m_cnt) : 1;
                m_owner = 1; m_last = 1'b0;
            end else if (gb) begin
                m_cnt = (m_owner == 2) ? ((m_cnt < MAXB) ? m_cnt + 1 : m_cnt) : 1;
                m_owner = 2; m_last = 1'b1;
            end else begin
                m_owner = 0; m_cnt = 0;
            end
        end
    end

    typedef struct {
        logic          r, ra, wa;
        logic [AW-1:0] aa;
        logic [DW-1:0] da;
        logic          rb, wb;
        logic [AW-1:0] ab;
        logic [DW-1:0] db;
        logic          ega, egb, eva;
        logic [DW-1:0] eda;
        logic          evb;
        logic [DW-1:0] edb;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(
        input logic r, ra, wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
        input logic rb, wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
        input logic ega, egb, eva, input logic [DW-1:0] eda,
        input logic evb, input logic [DW-1:0] edb);
        vec_t v;
        v.r = r; v.ra = ra; v.wa = wa; v.aa = aa; v.da = da;
        v.rb = rb; v.wb = wb; v.ab = ab; v.db = db;
        v.ega = ega; v.egb = egb; v.eva = eva; v.eda = eda;
        v.evb = evb; v.edb = edb;
        return v;
    endfunction

    task automatic set_in(input logic r, ra, wa, input logic [AW-1:0] aa,
                          input logic [DW-1:0] da, input logic rb, wb,
                          input logic [AW-1:0] ab, input logic [DW-1:0] db);
        rst = r; req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
        req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
            next_cycle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        string order, exp_order;
        int    na, nb;

        tbl[0]  = mk(1, 1, 0, 0, 0,      1, 0, 0, 0,      0, 0, 0, 0,     0, 0);
        tbl[1]  = mk(1, 1, 0, 0, 0,      1, 0, 0, 0,      0, 0, 0, 0,     0, 0);
        tbl[2]  = mk(0, 1, 1, 3, 8'h5A,  1, 1, 9, 8'h11,  1, 0, 0, 0,     0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0,      1, 1, 9, 8'h11,  0, 1, 0, 0,     0, 0);
        tbl[4]  = mk(0, 1, 0, 3, 0,      0, 0, 0, 0,      1, 0, 0, 0,     0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0,      0, 0, 0, 0,      0, 0, 1, 8'h5A, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0,      1, 1, 7, 8'h33,  0, 1, 0, 0,     0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 0,     0, 0);
        tbl[8]  = mk(0, 1, 0, 7, 0,      1, 0, 9, 0,      1, 0, 0, 0,     0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0,      1, 0, 9, 0,      0, 1, 1, 8'h33, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 0,     1, 8'h11);

        next_cycle();
        foreach (tbl[i]) begin
            set_in(tbl[i].r, tbl[i].ra, tbl[i].wa, tbl[i].aa, tbl[i].da,
                   tbl[i].rb, tbl[i].wb, tbl[i].ab, tbl[i].db);
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  32'({gnt_a, gnt_b, rvalid_a, rdata_a, rvalid_b, rdata_b}),
                  32'({tbl[i].ega, tbl[i].egb, tbl[i].eva, tbl[i].eda,
                       tbl[i].evb, tbl[i].edb}));
            next_cycle();
        end

        // Fill from A, then drain from B back-to-back.
        for (int i = 0; i < 16; i++) begin
            set_in(0, 1, 1, AW'(i), DW'(i + 1), 0, 0, 0, 0);
            next_cycle();
        end
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) set_in(0, 0, 0, 0, 0, 1, 0, AW'(i), 0);
            else        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            if (i > 0)
                check($sformatf("drain%0d", i - 1),
                      32'({rvalid_b, rdata_b}), 32'({1'b1, DW'(i)}));
            next_cycle();
        end
        idle(2);

        // Contention: A reads 0..3, B reads 8..11, each holds req until done.
        order = "";
        na = 0;
        nb = 0;
        for (int c = 0; c < 20 && (na < 4 || nb < 4); c++) begin
            set_in(0, na < 4, 0, AW'(na), 0, nb < 4, 0, AW'(8 + nb), 0);
            @(negedge clk);
            if (gnt_a) begin order = {order, "A"}; na++; end
            if (gnt_b) begin order = {order, "B"}; nb++; end
            next_cycle();
        end
`ifdef RAM_ARB_BURST_EN
        exp_order = "AAAABBBB";
`else
        exp_order = "ABABABAB";
`endif
        check_str("contention_order", order, exp_order);
        idle(2);

        // Read accepted, then reset: response lost, A wins first tie after.
        set_in(0, 1, 0, 5, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("midrst_gnt", 32'(gnt_a), 32'(1));
        next_cycle();
        set_in(1, 1, 0, 0, 0, 1, 0, 1, 0);
        @(negedge clk);
        check("midrst_quiet",
              32'({gnt_a, gnt_b, ram_port_en_0, rvalid_a, rdata_a}), 32'(0));
        next_cycle();
        set_in(0, 1, 0, 0, 0, 1, 0, 1, 0);
        @(negedge clk);
        check("post_rst_tie", 32'({gnt_a, gnt_b, rvalid_a}), 32'({3'b100}));
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("post_rst_read", 32'({rvalid_a, rdata_a}), 32'({1'b1, 8'd1}));
        next_cycle();
        idle(1);

`ifdef RAM_ARB_BURST_EN
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        order = "";
        for (int c = 0; c < 12; c++) begin
            set_in(0, 1, 0, AW'(c), 0, 1, 0, AW'(c + 4), 0);
            @(negedge clk);
            if (gnt_a) order = {order, "A"};
            if (gnt_b) order = {order, "B"};
            next_cycle();
        end
        check_str("burst_order", order, "AAAABBBBAAAA");
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        order = "";
        na = 0;
        for (int c = 0; c < 3; c++) begin
            set_in(0, na < 2, 0, 2, 0, 1, 0, 6, 0);
            @(negedge clk);
            if (gnt_a) begin order = {order, "A"}; na++; end
            if (gnt_b) order = {order, "B"};
            next_cycle();
        end
        check_str("burst_drop", order, "AAB");
        idle(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
